// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: read-owner encoding,
// default fairness bound and byte-to-word address conversion.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int MEM_AW_DEF     = 10;

    // Word index of a byte address; callers truncate to their RAM width, which
    // makes out-of-range addresses wrap modulo the RAM size.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> 32'd2;
    endfunction

endpackage

// File: rtl/dmem_arb_fairness.sv
// Starvation counter for the external port and the resulting external-win
// decision: the CPU has priority until the external side has lost STARVE_MAX cycles.
module dmem_arb_fairness
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic ext_req,
    output logic ext_win
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_nxt_s;
    logic             at_max_s;

    // Win decision and saturating next count
    always_comb begin
        at_max_s       = (wait_cnt_r == CNT_W'(STARVE_MAX));
        ext_win        = ext_req & (~cpu_req | at_max_s);
        wait_cnt_nxt_s = wait_cnt_r;
        if (ext_win | ~ext_req) begin
            wait_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (~at_max_s) begin
            wait_cnt_nxt_s = wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Wait counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the Memory stage and an external host
// port: CPU-priority grant mux, pipeline stall and read-data return routing.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_AW     = MEM_AW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic   ext_win_s;
    logic   cpu_gnt_s;
    owner_e rd_owner_r;
    owner_e rd_owner_nxt_s;
    logic [31:0] cpu_hold_r;

    dmem_arb_fairness #(
        .STARVE_MAX (STARVE_MAX)
    ) u_fairness (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (cpu_req),
        .ext_req (ext_req),
        .ext_win (ext_win_s)
    );

    // Grant mux: the winner drives the RAM, everything is zero when idle
    always_comb begin
        cpu_gnt_s = cpu_req & ~ext_win_s;
        ext_gnt   = ext_win_s;
        cpu_stall = cpu_req & ~cpu_gnt_s;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {MEM_AW{1'b0}};
        mem_wdata = 32'h0000_0000;
        if (ext_win_s) begin
            mem_en    = 1'b1;
            mem_we    = ext_we;
            mem_addr  = MEM_AW'(word_index(ext_addr));
            mem_wdata = ext_wdata;
        end else if (cpu_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = MEM_AW'(word_index(cpu_addr));
            mem_wdata = cpu_wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // Who owns the RAM read data arriving next cycle
    always_comb begin
        rd_owner_nxt_s = OWN_NONE;
        if (cpu_gnt_s & ~cpu_we) begin
            rd_owner_nxt_s = OWN_CPU;
        end else if (ext_win_s & ~ext_we) begin
            rd_owner_nxt_s = OWN_EXT;
        end else begin
            rd_owner_nxt_s = OWN_NONE;
        end
    end

    // Read owner and held CPU load data; a read granted under reset is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_r <= OWN_NONE;
            cpu_hold_r <= 32'h0000_0000;
        end else begin
            rd_owner_r <= rd_owner_nxt_s;
            if (rd_owner_r == OWN_CPU) begin
                cpu_hold_r <= mem_rdata;
            end
        end
    end

    // Read return routing; the CPU sees its last load until the next one lands
    always_comb begin
        ext_rdata  = mem_rdata;
        ext_rvalid = 1'b0;
        cpu_rdata  = cpu_hold_r;
        case (rd_owner_r)
            OWN_CPU: cpu_rdata  = mem_rdata;
            OWN_EXT: ext_rvalid = 1'b1;
            OWN_NONE: cpu_rdata = cpu_hold_r;
            default: begin
                ext_rvalid = 1'b0;
                cpu_rdata  = cpu_hold_r;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and a cycle-level
// reference model compared on every falling edge, plus literal spot checks.
module tb_dmem_arbiter;

    localparam int AW    = 10;
    localparam int SM    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          ext_req, ext_we;
    logic [31:0]   ext_addr, ext_wdata;
    logic          ext_gnt, ext_rvalid;
    logic [31:0]   ext_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    dmem_arbiter #(.MEM_AW(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Single-port RAM with one-cycle read latency
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    // Reference model: memory image, cycles the external side has lost,
    // pending read (0 none, 1 cpu, 2 ext) and the CPU's last load value
    logic [31:0] mmem [DEPTH];
    int          m_wait = 0;
    int          m_pend = 0;
    logic [31:0] m_pend_data = 32'h0;
    logic [31:0] m_hold = 32'h0;
    bit          chk_en = 1'b0;
    bit          e_ew, e_cg;

    function automatic logic [AW-1:0] widx(input logic [31:0] a);
        return AW'(a >> 2);
    endfunction

    always @(posedge clk) begin
        e_ew = ext_req && (!cpu_req || m_wait >= SM);
        e_cg = cpu_req && !e_ew;
        if (reset) begin
            m_wait = 0; m_pend = 0; m_hold = 32'h0;
        end else begin
            if (m_pend == 1) m_hold = m_pend_data;
            if (e_ew && !ext_we) begin
                m_pend = 2; m_pend_data = mmem[widx(ext_addr)];
            end else if (e_cg && !cpu_we) begin
                m_pend = 1; m_pend_data = mmem[widx(cpu_addr)];
            end else begin
                m_pend = 0;
            end
            if (e_ew || !ext_req) m_wait = 0;
            else if (m_wait < SM) m_wait = m_wait + 1;
        end
        if (e_ew && ext_we) mmem[widx(ext_addr)] = ext_wdata;
        else if (e_cg && cpu_we) mmem[widx(cpu_addr)] = cpu_wdata;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_ew = ext_req && (!cpu_req || m_wait >= SM);
            e_cg = cpu_req && !e_ew;
            chk("m_ext_gnt", 32'(ext_gnt), 32'(e_ew));
            chk("m_cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cg));
            chk("m_mem_en", 32'(mem_en), 32'(e_ew || e_cg));
            if (e_ew) begin
                chk("m_mem_we", 32'(mem_we), 32'(ext_we));
                chk("m_mem_addr", 32'(mem_addr), 32'(widx(ext_addr)));
                chk("m_mem_wdata", mem_wdata, ext_wdata);
            end else if (e_cg) begin
                chk("m_mem_we", 32'(mem_we), 32'(cpu_we));
                chk("m_mem_addr", 32'(mem_addr), 32'(widx(cpu_addr)));
                chk("m_mem_wdata", mem_wdata, cpu_wdata);
            end else begin
                chk("m_idle_mem", {mem_wdata[31:1], mem_we | (|mem_addr) | mem_wdata[0]}, 32'h0);
            end
            chk("m_ext_rvalid", 32'(ext_rvalid), 32'(m_pend == 2));
            if (m_pend == 2) chk("m_ext_rdata", ext_rdata, m_pend_data);
            chk("m_cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pend_data : m_hold);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ext(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = 32'h0BAD_0000 | 32'(i);
            mmem[i] = 32'h0BAD_0000 | 32'(i);
        end
        ram[16]   = 32'h1234_5678; mmem[16]   = 32'h1234_5678;
        ram[8'hC0] = 32'hA5A5_A5A5; mmem[8'hC0] = 32'hA5A5_A5A5;
        mem_rdata = 32'h0;
        reset = 1'b1;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        at_neg();
        chk("rst_ext_rvalid", 32'(ext_rvalid), 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        tick();

        // external read of preloaded word 0x10
        set_ext(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        at_neg();
        chk("ext_only_gnt", 32'(ext_gnt), 32'h1);
        tick();
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        chk("ext_only_rvalid", 32'(ext_rvalid), 32'h1);
        chk("ext_only_rdata", ext_rdata, 32'h1234_5678);
        tick();
        at_neg();
        chk("ext_only_pulse", 32'(ext_rvalid), 32'h0);
        tick();

        // CPU write then read back
        set_cpu(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        at_neg();
        chk("cpu_wr_stall", 32'(cpu_stall), 32'h0);
        chk("cpu_wr_addr", 32'(mem_addr), 32'h10);
        tick();
        set_cpu(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        at_neg();
        chk("cpu_rd_stall", 32'(cpu_stall), 32'h0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        chk("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);
        chk("cpu_rd_no_ext", 32'(ext_rvalid), 32'h0);
        tick();

        // sustained contention: ext wins every fifth cycle
        set_cpu(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        set_ext(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        for (int k = 0; k < 10; k++) begin
            at_neg();
            chk($sformatf("cont_stall_%0d", k), 32'(cpu_stall), 32'((k % 5) == 4));
            chk($sformatf("cont_egnt_%0d", k), 32'(ext_gnt), 32'((k % 5) == 4));
            tick();
        end
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);

        // held CPU load data across external reads
        set_cpu(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_ext(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        at_neg();
        chk("hold_c0", cpu_rdata, 32'hA5A5_A5A5);
        tick();
        set_ext(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        at_neg();
        chk("hold_c1", cpu_rdata, 32'hA5A5_A5A5);
        chk("hold_ext1", ext_rdata, 32'hDEAD_BEEF);
        tick();
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        chk("hold_c2", cpu_rdata, 32'hA5A5_A5A5);
        chk("hold_ext2", ext_rdata, 32'h0BAD_0011);
        tick();

        // reset while an external read is granted
        set_ext(1'b1, 1'b0, 32'h0000_0080, 32'h0);
        reset = 1'b1;
        at_neg();
        chk("rstrd_gnt", 32'(ext_gnt), 32'h1);
        tick();
        reset = 1'b0;
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        chk("rstrd_rvalid", 32'(ext_rvalid), 32'h0);
        chk("rstrd_cpu_rdata", cpu_rdata, 32'h0);
        tick();

        // reset clears a partly built wait count
        set_cpu(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        set_ext(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk($sformatf("rstwait_egnt_%0d", k), 32'(ext_gnt), 32'(k == 4));
            tick();
        end

        // dropping ext_req before grant restarts the count
        tick(); tick();
        ext_req = 1'b0;
        tick();
        ext_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk($sformatf("drop_egnt_%0d", k), 32'(ext_gnt), 32'(k == 4));
            tick();
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);

        // address wrap: 0x1004 and 0x0004 alias the same word
        set_cpu(1'b1, 1'b1, 32'h0000_1004, 32'hCAFE_F00D);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_ext(1'b1, 1'b0, 32'h0000_0004, 32'h0);
        at_neg();
        chk("wrap_gnt", 32'(ext_gnt), 32'h1);
        tick();
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        chk("wrap_rdata", ext_rdata, 32'hCAFE_F00D);
        tick();

        // external write observed by a CPU load
        set_ext(1'b1, 1'b1, 32'h0000_0050, 32'h1111_2222);
        tick();
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        set_cpu(1'b1, 1'b0, 32'h0000_0050, 32'h0);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        chk("extwr_cpu_rdata", cpu_rdata, 32'h1111_2222);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
